// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: ALU operations, opcodes, funct3 values,
// immediate formats, the control bundle carried into execute, and the
// immediate/ALU-op helper functions.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // Control bits that a bubble must clear.
    typedef struct packed {
        logic alu_src_imm;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA; callers only raise it where bit 30 is meaningful.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hard-wired to zero. With DECODE_WB_BYPASS_EN defined the read ports
// forward the same-cycle write-back data (write-first); otherwise they
// return the stored value (read-first).
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [0:NREGS-1];

    // Write port; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports with x0 forced to zero and optional write-back forwarding.
    always_comb begin
        rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
        rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`ifdef DECODE_WB_BYPASS_EN
        if (we_i && (wa_i != '0) && (wa_i == ra1_i)) rd1_o = wd_i;
        if (we_i && (wa_i != '0) && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: instruction decode, register read, immediate
// generation, load-use stall and the decode/execute pipeline register.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-back forwarding in the
// register file; without it a same-cycle write-back to a used source stalls).
import riscv_pkg::*;

module decode #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic            ex_mem_read_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            conflict_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [3:0]      alu_op_o,
    output logic            alu_src_imm_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            reg_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_rd, rs2_rd;
    imm_fmt_e        fmt;
    alu_op_e         alu_dec;
    ctrl_t           ctrl_dec;
    logic            use_rs1, use_rs2;
    logic            ld_hit, wb_hit, bubble;

    logic            valid_d, valid_q;
    logic [XLEN-1:0] pc_d, pc_q, rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q;
    logic [4:0]      rd_d, rd_q;
    logic [2:0]      f3_d, f3_q;
    alu_op_e         alu_d, alu_q;
    ctrl_t           ctrl_d, ctrl_q;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rs1_rd),
        .rd2_o (rs2_rd),
        .we_i  (wb_we_i),
        .wa_i  (wb_rd_i),
        .wd_i  (wb_data_i)
    );

    // Opcode decode: immediate format, controls and which sources are read.
    always_comb begin
        fmt      = IMM_NONE;
        alu_dec  = ALU_ADD;
        ctrl_dec = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt = IMM_U; alu_dec = ALU_PASS_B;
                ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = IMM_U;
                ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J;
                ctrl_dec.reg_write = 1'b1; ctrl_dec.jump = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                fmt = IMM_I; use_rs1 = 1'b1;
                ctrl_dec.reg_write = 1'b1; ctrl_dec.jump = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = IMM_B; alu_dec = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ctrl_dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                fmt = IMM_I; use_rs1 = 1'b1;
                ctrl_dec.mem_read = 1'b1; ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; use_rs1 = 1'b1;
                alu_dec = alu_from_f3(funct3, inst_i[30] && (funct3 == F3_SR));
                ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src_imm = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu_dec = alu_from_f3(funct3, inst_i[30]);
                ctrl_dec.reg_write = 1'b1;
            end
            default: ctrl_dec.illegal = 1'b1;
        endcase
    end

    // Stall request: load-use always; same-cycle write-back only without forwarding.
    always_comb begin
        ld_hit = ex_mem_read_i && (ex_rd_i != '0) &&
                 ((use_rs1 && (ex_rd_i == rs1)) || (use_rs2 && (ex_rd_i == rs2)));
`ifdef DECODE_WB_BYPASS_EN
        wb_hit = 1'b0;
`else
        wb_hit = wb_we_i && (wb_rd_i != '0) &&
                 ((use_rs1 && (wb_rd_i == rs1)) || (use_rs2 && (wb_rd_i == rs2)));
`endif
        conflict_o = !flush_i && (ld_hit || wb_hit);
    end

    // Next state of the execute register: flush, stall and the all-zero word are bubbles.
    always_comb begin
        bubble  = flush_i || conflict_o || (inst_i == 32'h0);
        pc_d    = pc_i;
        rs1_d   = rs1_rd;
        rs2_d   = rs2_rd;
        imm_d   = gen_imm(inst_i, fmt);
        rd_d    = inst_i[11:7];
        f3_d    = funct3;
        alu_d   = alu_dec;
        valid_d = !bubble;
        ctrl_d  = bubble ? '0 : ctrl_dec;
    end

    // Decode/execute pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            alu_q   <= ALU_ADD;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            alu_q   <= alu_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign rs1_data_o    = rs1_q;
    assign rs2_data_o    = rs2_q;
    assign imm_o         = imm_q;
    assign rd_o          = rd_q;
    assign funct3_o      = f3_q;
    assign alu_op_o      = alu_q;
    assign alu_src_imm_o = ctrl_q.alu_src_imm;
    assign mem_read_o    = ctrl_q.mem_read;
    assign mem_write_o   = ctrl_q.mem_write;
    assign reg_write_o   = ctrl_q.reg_write;
    assign branch_o      = ctrl_q.branch;
    assign jump_o        = ctrl_q.jump;
    assign illegal_o     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for the RV32I decode stage: table of vectors with a scoreboard queue
// holding the expected execute-register contents one cycle later, plus a
// hand-written asynchronous reset sequence.
module tb_decode;
    import riscv_pkg::*;

    localparam logic [6:0] C_SRC = 7'b1000000;
    localparam logic [6:0] C_MR  = 7'b0100000;
    localparam logic [6:0] C_MW  = 7'b0010000;
    localparam logic [6:0] C_RW  = 7'b0001000;
    localparam logic [6:0] C_BR  = 7'b0000100;
    localparam logic [6:0] C_JP  = 7'b0000010;
    localparam logic [6:0] C_IL  = 7'b0000001;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i, pc_i, wb_data_i;
    logic        flush_i, ex_mem_read_i, wb_we_i;
    logic [4:0]  ex_rd_i, wb_rd_i;
    logic        conflict_o, valid_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;
    logic        alu_src_imm_o, mem_read_o, mem_write_o, reg_write_o, branch_o, jump_o, illegal_o;

    decode dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .conflict_o(conflict_o),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rd_o(rd_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o),
        .alu_src_imm_o(alu_src_imm_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic        flush, exmr, we;
        logic [4:0]  exrd, wrd;
        logic [31:0] wdata;
        logic        conflict, valid;
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic [31:0] pc, imm, rs1, rs2;
        logic [4:0]  rd;
        logic        chk_imm, chk_rs1, chk_rs2, chk_rd;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t base(input logic [31:0] inst);
        vec_t v;
        v.inst = inst; v.flush = 0; v.exmr = 0; v.exrd = 0; v.we = 0; v.wrd = 0; v.wdata = 0;
        v.conflict = 0; v.valid = 0; v.ctrl = 0; v.alu = ALU_ADD; v.pc = 0;
        v.imm = 0; v.rs1 = 0; v.rs2 = 0; v.rd = 0;
        v.chk_imm = 0; v.chk_rs1 = 0; v.chk_rs2 = 0; v.chk_rd = 0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " valid"}, {31'b0, valid_o}, 0);
        chk({tag, " ctrl"}, {25'b0, alu_src_imm_o, mem_read_o, mem_write_o, reg_write_o,
                             branch_o, jump_o, illegal_o}, 0);
        chk({tag, " pc"}, pc_o, 0);
        chk({tag, " imm"}, imm_o, 0);
        chk({tag, " rd"}, {27'b0, rd_o}, 0);
        chk({tag, " rs1"}, rs1_data_o, 0);
        chk({tag, " alu"}, {28'b0, alu_op_o}, 0);
    endtask

    initial begin
        vec_t v, e;
        rst_i = 1; inst_i = 0; pc_i = 0; flush_i = 0; ex_mem_read_i = 0; ex_rd_i = 0;
        wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;

        // v0: addi x1,x0,5
        v = base(32'h00500093); v.valid = 1; v.ctrl = C_SRC | C_RW; v.rd = 1; v.chk_rd = 1;
        v.imm = 5; v.chk_imm = 1; v.chk_rs1 = 1; tbl.push_back(v);
        // v1/v2: write x1=5, x2=7 behind bubbles
        v = base(0); v.we = 1; v.wrd = 1; v.wdata = 5; tbl.push_back(v);
        v = base(0); v.we = 1; v.wrd = 2; v.wdata = 7; tbl.push_back(v);
        // v3: load-use on rs1 (add x3,x2,x1)
        v = base(32'h001101B3); v.exmr = 1; v.exrd = 2; v.conflict = 1; tbl.push_back(v);
        // v4: load gone, re-decode
        v = base(32'h001101B3); v.valid = 1; v.ctrl = C_RW; v.rd = 3; v.chk_rd = 1;
        v.rs1 = 7; v.rs2 = 5; v.chk_rs1 = 1; v.chk_rs2 = 1; tbl.push_back(v);
        // v5: beq x0,x0,-4
        v = base(32'hFE000EE3); v.valid = 1; v.ctrl = C_BR; v.alu = ALU_SUB;
        v.imm = 32'hFFFFFFFC; v.chk_imm = 1; v.chk_rs1 = 1; v.chk_rs2 = 1; tbl.push_back(v);
        // v6: illegal
        v = base(32'hFFFFFFFF); v.valid = 1; v.ctrl = C_IL; tbl.push_back(v);
        // v7: flush with a hazard present
        v = base(32'h001101B3); v.flush = 1; v.exmr = 1; v.exrd = 2; tbl.push_back(v);
        // v8: write x0 while reading it, v9: read it again
        v = base(32'h00000013); v.we = 1; v.wrd = 0; v.wdata = 32'h1234; v.valid = 1;
        v.ctrl = C_SRC | C_RW; v.chk_rs1 = 1; v.chk_imm = 1; tbl.push_back(v);
        v = base(32'h00000013); v.valid = 1; v.ctrl = C_SRC | C_RW; v.chk_rs1 = 1;
        v.chk_imm = 1; tbl.push_back(v);
        // v10: lui x5,0x12345 ; load in execute targets x8 (the rs1 field) but U reads nothing
        v = base(32'h123452B7); v.exmr = 1; v.exrd = 8; v.valid = 1; v.ctrl = C_SRC | C_RW;
        v.alu = ALU_PASS_B; v.imm = 32'h12345000; v.chk_imm = 1; v.rd = 5; v.chk_rd = 1;
        tbl.push_back(v);
        // v11: sw x1,8(x2)
        v = base(32'h00112423); v.valid = 1; v.ctrl = C_SRC | C_MW; v.imm = 8; v.chk_imm = 1;
        v.rs1 = 7; v.rs2 = 5; v.chk_rs1 = 1; v.chk_rs2 = 1; tbl.push_back(v);
        // v12: jal x1,-8
        v = base(32'hFF9FF0EF); v.valid = 1; v.ctrl = C_SRC | C_RW | C_JP;
        v.imm = 32'hFFFFFFF8; v.chk_imm = 1; v.rd = 1; v.chk_rd = 1; tbl.push_back(v);
        // v13: lw x4,-4(x1)
        v = base(32'hFFC0A203); v.valid = 1; v.ctrl = C_SRC | C_MR | C_RW;
        v.imm = 32'hFFFFFFFC; v.chk_imm = 1; v.rs1 = 5; v.chk_rs1 = 1; v.rd = 4; v.chk_rd = 1;
        tbl.push_back(v);
        // v14: add x6,x5,x0 with a same-cycle write-back of x5
        v = base(32'h00028333); v.we = 1; v.wrd = 5; v.wdata = 32'hDEADBEEF;
`ifdef DECODE_WB_BYPASS_EN
        v.valid = 1; v.ctrl = C_RW; v.rs1 = 32'hDEADBEEF; v.chk_rs1 = 1; v.chk_rs2 = 1;
        v.rd = 6; v.chk_rd = 1;
`else
        v.conflict = 1;
`endif
        tbl.push_back(v);
        // v15: same instruction after the write has landed
        v = base(32'h00028333); v.valid = 1; v.ctrl = C_RW; v.rs1 = 32'hDEADBEEF;
        v.chk_rs1 = 1; v.chk_rs2 = 1; v.rd = 6; v.chk_rd = 1; tbl.push_back(v);
        // v16: load-use on rs2 only
        v = base(32'h001101B3); v.exmr = 1; v.exrd = 1; v.conflict = 1; tbl.push_back(v);
        // v17: load targets the destination, not a source
        v = base(32'h001101B3); v.exmr = 1; v.exrd = 3; v.valid = 1; v.ctrl = C_RW;
        v.rs1 = 7; v.rs2 = 5; v.chk_rs1 = 1; v.chk_rs2 = 1; tbl.push_back(v);
        // v18: load into x0 never stalls
        v = base(32'h00000013); v.exmr = 1; v.exrd = 0; v.valid = 1; v.ctrl = C_SRC | C_RW;
        tbl.push_back(v);
        // v19: plain flush
        v = base(32'h00500093); v.flush = 1; tbl.push_back(v);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk_zero_outputs("reset");
        chk("reset conflict", {31'b0, conflict_o}, 0);
        @(negedge clk_i);
        rst_i = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            v.pc = 32'h100 + 32'(i) * 4;
            @(negedge clk_i);
            inst_i = v.inst; pc_i = v.pc; flush_i = v.flush; ex_mem_read_i = v.exmr;
            ex_rd_i = v.exrd; wb_we_i = v.we; wb_rd_i = v.wrd; wb_data_i = v.wdata;
            #1;
            chk($sformatf("v%0d conflict", i), {31'b0, conflict_o}, {31'b0, v.conflict});
            sb.push_back(v);
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d valid", i), {31'b0, valid_o}, {31'b0, e.valid});
            chk($sformatf("v%0d ctrl", i), {25'b0, alu_src_imm_o, mem_read_o, mem_write_o,
                reg_write_o, branch_o, jump_o, illegal_o}, {25'b0, e.ctrl});
            if (e.valid) begin
                chk($sformatf("v%0d pc", i), pc_o, e.pc);
                chk($sformatf("v%0d alu", i), {28'b0, alu_op_o}, {28'b0, e.alu});
                if (e.chk_imm) chk($sformatf("v%0d imm", i), imm_o, e.imm);
                if (e.chk_rs1) chk($sformatf("v%0d rs1", i), rs1_data_o, e.rs1);
                if (e.chk_rs2) chk($sformatf("v%0d rs2", i), rs2_data_o, e.rs2);
                if (e.chk_rd)  chk($sformatf("v%0d rd", i), {27'b0, rd_o}, {27'b0, e.rd});
            end
        end

        // Asynchronous reset mid-stream clears the execute register and the register file.
        @(negedge clk_i);
        inst_i = 32'h00500093; pc_i = 32'h200; flush_i = 0; ex_mem_read_i = 0; wb_we_i = 0;
        @(posedge clk_i);
        #1;
        chk("pre-reset valid", {31'b0, valid_o}, 1);
        #2;
        rst_i = 1;
        #1;
        chk_zero_outputs("async reset");
        @(negedge clk_i);
        rst_i = 0;
        inst_i = 32'h001101B3; pc_i = 32'h204;
        @(posedge clk_i);
        #1;
        chk("post-reset valid", {31'b0, valid_o}, 1);
        chk("post-reset x2", rs1_data_o, 0);
        chk("post-reset x1", rs2_data_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
